// File: rtl/final_core_pkg.sv
// ----------------------------------------------------------------------------
// final_core_pkg
// Shared constants for the final_core pipeline.
//   XLEN             : architectural address/data width (32 only)
//   INSTR_BYTES      : size of one instruction word in bytes (PC increment)
//   RESET_PC_DEFAULT : default first fetch address after reset
//   NOP              : value driven on the instruction bus when nothing is valid
// ----------------------------------------------------------------------------
package final_core_pkg;

   localparam int          XLEN             = 32;
   localparam logic [31:0] INSTR_BYTES      = 32'd4;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP              = 32'h0000_0000;

endpackage : final_core_pkg

// File: rtl/add32.sv
// ----------------------------------------------------------------------------
// add32
// Plain 32-bit wrapping adder; the carry out is intentionally dropped.
// Ports:
//   a, b : 32-bit operands
//   sum  : (a + b) mod 2^32
// ----------------------------------------------------------------------------
module add32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] sum
);

   assign sum = a + b;

endmodule : add32

// File: rtl/if_fetch_skid.sv
// ----------------------------------------------------------------------------
// fetch_skid
// One-entry skid buffer holding a fetched {pc, instr} pair while decode
// stalls. Flush (redirect) wins over capture, capture wins over drain.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   capture         : load in_pc/in_instr and mark the entry valid
//   drain           : entry consumed by decode, clear valid
//   flush           : discard the entry
//   in_pc, in_instr : pair to capture
//   valid, pc, instr: buffer contents
// ----------------------------------------------------------------------------
module fetch_skid
   import final_core_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            capture,
   input  logic            drain,
   input  logic            flush,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_instr,
   output logic            valid,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] instr
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         pc    <= '0;
         instr <= NOP;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (capture) begin
         valid <= 1'b1;
         pc    <= in_pc;
         instr <= in_instr;
      end else if (drain) begin
         valid <= 1'b0;
      end
   end

endmodule : fetch_skid

// File: rtl/if_fetch.sv
// ----------------------------------------------------------------------------
// if_fetch
// Instruction-fetch stage: holds the PC, issues word reads to a synchronous
// ROM (data returns the cycle after imem_en), and hands {pc, instr, pc+4} to
// decode over valid/ready. A one-entry skid buffer catches the ROM response
// when decode stalls so no word is dropped or duplicated. Redirects from EX
// take priority, flush the in-flight word and the buffer, and refetch.
//
// Optional feature macro: FETCH_STALL_CNT_EN
//   defined   : stall_cnt counts (wrapping) cycles with if_valid & !if_ready
//   undefined : stall_cnt is constant zero, no counter flops
//
// Parameters:
//   XLEN     : width, 32 only
//   RESET_PC : first fetch address after reset
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   imem_en/imem_addr : ROM read strobe and byte address
//   imem_rdata        : ROM data, valid the cycle after imem_en
//   redirect_valid/pc : PC change request from EX
//   if_valid/if_ready : handshake to decode
//   if_pc/if_instr/if_pc_plus4 : delivered instruction and its address
//   stall_cnt         : backpressure cycle counter
// ----------------------------------------------------------------------------
module if_fetch #(
   parameter int              XLEN     = final_core_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC = final_core_pkg::RESET_PC_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_en,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_instr,
   output logic [XLEN-1:0] if_pc_plus4,
   output logic [XLEN-1:0] stall_cnt
);

   import final_core_pkg::*;

   logic [XLEN-1:0] pc_q;
   logic            infl;
   logic [XLEN-1:0] infl_pc;

   logic            buf_v;
   logic [XLEN-1:0] buf_pc;
   logic [XLEN-1:0] buf_instr;

   logic            present;
   logic            issue;
   logic            capture;
   logic            drain;
   logic [XLEN-1:0] next_pc;
   logic [XLEN-1:0] out_pc_plus4;

   // Something is available for decode: either the buffered word or the
   // ROM response arriving this cycle.
   assign present  = buf_v | infl;
   assign if_valid = present & ~redirect_valid;

   // Redirect always issues. Otherwise issue only when the buffer is empty
   // and the current response (if any) is being consumed this cycle, so the
   // next response always has somewhere to go.
   assign issue     = redirect_valid | (~buf_v & (~infl | if_ready));
   assign imem_addr = redirect_valid ? redirect_pc : pc_q;
   // The state is held in reset anyway; gating here only keeps the strobe
   // low while rst is asserted.
   assign imem_en   = issue & ~rst;

   // The ROM word is only valid in its response cycle, so it must be
   // captured then if decode is not taking it.
   assign capture = infl & ~buf_v & ~if_ready & ~redirect_valid;
   assign drain   = buf_v & if_ready & ~redirect_valid;

   always_comb begin
      if_pc    = '0;
      if_instr = NOP;
      if (buf_v) begin
         if_pc    = buf_pc;
         if_instr = buf_instr;
      end else if (infl) begin
         if_pc    = infl_pc;
         if_instr = imem_rdata;
      end
   end

   add32 u_next_pc_add (
      .a   (imem_addr),
      .b   (INSTR_BYTES),
      .sum (next_pc)
   );

   add32 u_out_pc_add (
      .a   (if_pc),
      .b   (INSTR_BYTES),
      .sum (out_pc_plus4)
   );

   assign if_pc_plus4 = present ? out_pc_plus4 : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         infl    <= 1'b0;
         infl_pc <= '0;
      end else if (issue) begin
         pc_q    <= next_pc;
         infl    <= 1'b1;
         infl_pc <= imem_addr;
      end else if (capture) begin
         infl <= 1'b0;
      end else begin
         infl <= infl & ~(if_valid & if_ready);
      end
   end

   fetch_skid u_skid (
      .clk      (clk),
      .rst      (rst),
      .capture  (capture),
      .drain    (drain),
      .flush    (redirect_valid),
      .in_pc    (infl_pc),
      .in_instr (imem_rdata),
      .valid    (buf_v),
      .pc       (buf_pc),
      .instr    (buf_instr)
   );

`ifdef FETCH_STALL_CNT_EN
   logic [XLEN-1:0] stall_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else if (if_valid & ~if_ready) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign stall_cnt = stall_cnt_q;
`else
   assign stall_cnt = '0;
`endif

endmodule : if_fetch

// File: tb/tb_if_fetch.sv
// ----------------------------------------------------------------------------
// tb_if_fetch
// Directed scenarios followed by randomized ready/redirect traffic. Expected
// delivery is modelled as a contiguous PC stream that restarts at each
// redirect target (or RESET_PC after reset); the ROM returns addr ^ KEY.
// ----------------------------------------------------------------------------
module tb_if_fetch;

   localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;
   localparam logic [31:0] KEY     = 32'hA5A5_A5A5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        imem_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = 32'h0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        if_valid;
   logic        if_ready = 1'b1;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic [31:0] if_pc_plus4;
   logic [31:0] stall_cnt;

   logic        w_imem_en;
   logic [31:0] w_imem_addr;
   logic [31:0] w_imem_rdata = 32'h0;
   logic        w_if_valid;
   logic [31:0] w_if_pc;
   logic [31:0] w_if_instr;
   logic [31:0] w_if_pc_plus4;
   logic [31:0] w_stall_cnt;

   if_fetch dut (
      .clk            (clk),
      .rst            (rst),
      .imem_en        (imem_en),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_pc          (if_pc),
      .if_instr       (if_instr),
      .if_pc_plus4    (if_pc_plus4),
      .stall_cnt      (stall_cnt)
   );

   if_fetch #(.RESET_PC(WRAP_PC)) dut_wrap (
      .clk            (clk),
      .rst            (rst),
      .imem_en        (w_imem_en),
      .imem_addr      (w_imem_addr),
      .imem_rdata     (w_imem_rdata),
      .redirect_valid (1'b0),
      .redirect_pc    (32'h0),
      .if_valid       (w_if_valid),
      .if_ready       (1'b1),
      .if_pc          (w_if_pc),
      .if_instr       (w_if_instr),
      .if_pc_plus4    (w_if_pc_plus4),
      .stall_cnt      (w_stall_cnt)
   );

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return a ^ KEY;
   endfunction

   // Synchronous ROMs; garbage outside response cycles so late sampling shows.
   always @(posedge clk) begin
      imem_rdata   <= imem_en   ? rom_word(imem_addr)   : $urandom;
      w_imem_rdata <= w_imem_en ? rom_word(w_imem_addr) : $urandom;
   end

   int errors = 0;
   int checks = 0;
   int handshakes = 0;
   logic [31:0] exp_q[$];
   logic [31:0] next_seq;
   logic [31:0] mon_exp;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      chk(name, {31'b0, act}, {31'b0, exp});
   endtask

   // Expected delivery stream: restart at a new origin, keep a few ahead.
   task automatic restart_stream(input logic [31:0] origin);
      exp_q.delete();
      next_seq = origin;
   endtask

   task automatic refill();
      while (exp_q.size() < 4) begin
         exp_q.push_back(next_seq);
         next_seq = next_seq + 32'd4;
      end
   endtask

   // One cycle of stimulus; returns at the following negedge for sampling.
   task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
      @(posedge clk);
      #1;
      if_ready       = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      if (rv) restart_stream(rpc);
      refill();
      @(negedge clk);
   endtask

   // Reset, check reset outputs, release; returns in the first cycle after.
   task automatic do_reset();
      rst = 1'b1;
      redirect_valid = 1'b0;
      @(posedge clk);
      #1;
      chk1("rst_if_valid", if_valid, 1'b0);
      chk1("rst_imem_en", imem_en, 1'b0);
      chk("rst_if_pc", if_pc, 32'h0);
      chk("rst_if_instr", if_instr, 32'h0);
      chk("rst_if_pc_plus4", if_pc_plus4, 32'h0);
      chk("rst_stall_cnt", stall_cnt, 32'h0);
      @(posedge clk);
      #1;
      rst      = 1'b0;
      if_ready = 1'b1;
      restart_stream(32'h0);
      refill();
      @(negedge clk);
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (!rst) begin
         if (redirect_valid) begin
            chk1("redirect_if_valid", if_valid, 1'b0);
            chk1("redirect_imem_en", imem_en, 1'b1);
            chk("redirect_imem_addr", imem_addr, redirect_pc);
         end
         if (if_valid && if_ready) begin
            handshakes++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL scoreboard_empty: got pc %h expected none queued", if_pc);
            end else begin
               mon_exp = exp_q.pop_front();
               chk("deliver_pc", if_pc, mon_exp);
               chk("deliver_instr", if_instr, rom_word(mon_exp));
               chk("deliver_pc_plus4", if_pc_plus4, mon_exp + 32'd4);
            end
         end
      end
   end

   initial begin : stim
      logic        r;
      logic        rv;
      logic [31:0] t;

      // Cycle 1: first request right after reset release.
      do_reset();
      chk1("c1_imem_en", imem_en, 1'b1);
      chk("c1_imem_addr", imem_addr, 32'h0);
      chk1("c1_if_valid", if_valid, 1'b0);
      chk("wrap_c1_addr", w_imem_addr, 32'hFFFF_FFF8);

      step(1'b1, 1'b0, 32'h0);   // cycle 2
      chk("c2_imem_addr", imem_addr, 32'h4);
      chk1("c2_if_valid", if_valid, 1'b1);
      chk("c2_if_pc", if_pc, 32'h0);
      chk("c2_if_pc_plus4", if_pc_plus4, 32'h4);
      chk("wrap_c2_addr", w_imem_addr, 32'hFFFF_FFFC);
      chk("wrap_c2_if_pc", w_if_pc, 32'hFFFF_FFF8);

      step(1'b1, 1'b0, 32'h0);   // cycle 3
      chk("c3_imem_addr", imem_addr, 32'h8);
      chk("c3_if_pc", if_pc, 32'h4);
      chk("c3_if_pc_plus4", if_pc_plus4, 32'h8);
      chk("wrap_c3_addr", w_imem_addr, 32'h0);
      chk("wrap_c3_if_pc", w_if_pc, 32'hFFFF_FFFC);
      chk("wrap_c3_pc_plus4", w_if_pc_plus4, 32'h0);

      // Stall three cycles with pc 0x8 in flight.
      step(1'b0, 1'b0, 32'h0);   // cycle 4
      chk1("stall1_if_valid", if_valid, 1'b1);
      chk("stall1_if_pc", if_pc, 32'h8);
      chk1("stall1_imem_en", imem_en, 1'b0);
      step(1'b0, 1'b0, 32'h0);   // cycle 5: buffered
      chk1("stall2_imem_en", imem_en, 1'b0);
      chk("stall2_if_pc", if_pc, 32'h8);
      chk("stall2_if_instr", if_instr, rom_word(32'h8));
      step(1'b0, 1'b0, 32'h0);   // cycle 6
      chk1("stall3_imem_en", imem_en, 1'b0);
      step(1'b1, 1'b0, 32'h0);   // cycle 7: drain
      chk("drain_if_pc", if_pc, 32'h8);
      chk1("drain_imem_en", imem_en, 1'b0);
`ifdef FETCH_STALL_CNT_EN
      chk("stall_cnt_after_stall", stall_cnt, 32'd3);
`else
      chk("stall_cnt_after_stall", stall_cnt, 32'd0);
`endif
      step(1'b1, 1'b0, 32'h0);   // cycle 8: bubble, restart
      chk1("bubble_if_valid", if_valid, 1'b0);
      chk("bubble_imem_addr", imem_addr, 32'hC);
      step(1'b1, 1'b0, 32'h0);   // cycle 9
      chk("post_stall_pc_c", if_pc, 32'hC);
      step(1'b1, 1'b0, 32'h0);   // cycle 10
      chk("post_stall_pc_10", if_pc, 32'h10);

      // Redirect while the buffer holds a word.
      step(1'b0, 1'b0, 32'h0);   // capture 0x14
      step(1'b1, 1'b1, 32'h100);
      chk1("redir_buf_if_valid", if_valid, 1'b0);
      chk("redir_buf_imem_addr", imem_addr, 32'h100);
      step(1'b1, 1'b0, 32'h0);
      chk("redir_next_if_pc", if_pc, 32'h100);
      chk1("redir_next_if_valid", if_valid, 1'b1);
      step(1'b1, 1'b0, 32'h0);
      chk("redir_follow_addr", imem_addr, 32'h108);

      // Asynchronous reset mid-stall with the buffer full.
      step(1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0);
      chk1("pre_async_if_valid", if_valid, 1'b1);
      #1 rst = 1'b1;
      #1;
      chk1("async_if_valid", if_valid, 1'b0);
      chk1("async_imem_en", imem_en, 1'b0);
      chk("async_if_pc", if_pc, 32'h0);
      chk("async_if_instr", if_instr, 32'h0);
      chk("async_if_pc_plus4", if_pc_plus4, 32'h0);
      do_reset();
      chk("restart_imem_addr", imem_addr, 32'h0);
      step(1'b1, 1'b0, 32'h0);
      chk("restart_if_pc", if_pc, 32'h0);

      // Randomized ready / redirect traffic.
      for (int i = 0; i < 2000; i++) begin
         r  = ($urandom_range(0, 3) != 0);
         rv = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 3) == 0)
            t = 32'hFFFF_FFF0 | ($urandom & 32'hC);
         else
            t = $urandom & 32'hFFFF_FFFC;
         step(r, rv, t);
      end
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);
      chk1("progress", handshakes > 400, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_if_fetch
